axi_master: RTL

- Directed AXI-style initiator test model for BufferlessModel unit tests.
- Drives the AR/R and AW/W channels of a slave model (no B channel, same subset as the slave side).
- Issues one read or one write burst per command and generates incrementing write data.
- Self-checks read data against the incrementing pattern (beat value = address + beat index) and checks rlast placement.

---
 rtl/axi_master_pkg.sv | 23 ++
 rtl/axi_master_rchk.sv | 74 +++++++
 rtl/axi_master.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/axi_master_pkg.sv
// Shared types and constants for the axi_master directed initiator model.
//   state_e    : initiator FSM states
//   *_W_DEF    : default widths used by axi_master and axi_master_rchk
//   WSTRB_ALL  : write strobe driven on every W beat
package axi_master_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAr,
    StR,
    StAw,
    StW,
    StDone
  } state_e;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 128;
  localparam int unsigned LEN_W_DEF  = 8;
  localparam int unsigned ERRC_W_DEF = 16;

  localparam logic [3:0] WSTRB_ALL = 4'hF;

endpackage

// File: rtl/axi_master_rchk.sv
// Read-data checker for axi_master.
// Compares each accepted R beat against the incrementing pattern
// (base_addr + beat_idx, zero-extended) and checks rlast placement.
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   beat_fire    : an R beat completes this cycle (rvalid && rready in R)
//   base_addr    : latched burst start address
//   beat_idx     : index of the beat completing now
//   is_last      : this beat is the final beat of the burst
//   rdata, rlast : beat payload from the slave
//   err          : sticky, any check failure since reset
//   err_cnt      : saturating count of check failures
module axi_master_rchk
  import axi_master_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned LEN_W  = LEN_W_DEF,
  parameter int unsigned ERRC_W = ERRC_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              beat_fire,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  beat_idx,
  input  logic              is_last,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rlast,
  output logic              err,
  output logic [ERRC_W-1:0] err_cnt
);

  localparam int unsigned SumW = ERRC_W + 1;

  logic [ADDR_W-1:0] exp_addr;
  logic [DATA_W-1:0] exp_data;
  logic              data_bad;
  logic              last_bad;
  logic [1:0]        n_bad;
  logic [SumW-1:0]   cnt_sum;

  logic              err_q, err_d;
  logic [ERRC_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    // Address arithmetic wraps at ADDR_W before zero-extension.
    exp_addr  = base_addr + ADDR_W'(beat_idx);
    exp_data  = DATA_W'(exp_addr);
    data_bad  = (rdata != exp_data);
    last_bad  = (rlast != is_last);
    n_bad     = {1'b0, data_bad} + {1'b0, last_bad};
    cnt_sum   = {1'b0, err_cnt_q} + SumW'(n_bad);
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    if (beat_fire && (n_bad != 2'd0)) begin
      err_d     = 1'b1;
      err_cnt_d = cnt_sum[ERRC_W] ? '1 : cnt_sum[ERRC_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err     = err_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: rtl/axi_master.sv
// Directed AXI-style initiator model: issues one read (AR/R) or one write
// (AW/W) burst per command, generates incrementing write data and checks
// incrementing read data. No B channel.
// Ports:
//   clk, rst_n                  : clock, async active-low reset
//   cmd_rd_start / cmd_wr_start : one-cycle start pulses (read wins on a tie)
//   cmd_addr, cmd_len           : burst start address and beats-1
//   busy, done                  : FSM not idle / one-cycle completion pulse
//   err, err_cnt                : sticky read-check error and saturating count
//   m1_ar*, m1_r*               : read address / read data channels
//   m1_aw*, m1_w*               : write address / write data channels
// All outputs are registered; wstrb is the constant WSTRB_ALL.
module axi_master
  import axi_master_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned LEN_W        = LEN_W_DEF,
  parameter int unsigned ERRC_W       = ERRC_W_DEF,
  parameter int unsigned RREADY_STALL = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_rd_start,
  input  logic              cmd_wr_start,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ERRC_W-1:0] err_cnt,
  output logic [ADDR_W-1:0] m1_araddr,
  output logic              m1_arvalid,
  input  logic              m1_arready,
  input  logic              m1_rvalid,
  input  logic [DATA_W-1:0] m1_rdata,
  input  logic              m1_rlast,
  output logic              m1_rready,
  output logic [ADDR_W-1:0] m1_awaddr,
  output logic              m1_awvalid,
  input  logic              m1_awready,
  output logic              m1_wvalid,
  output logic [DATA_W-1:0] m1_wdata,
  output logic [3:0]        m1_wstrb,
  output logic              m1_wlast,
  input  logic              m1_wready
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  beat_q, beat_d;
  logic [31:0]       stall_q, stall_d;

  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wlast_q, wlast_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [ADDR_W-1:0] wsum;
  logic              r_fire;

  assign r_fire = (state_q == StR) && m1_rvalid && rready_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    beat_d    = beat_q;
    stall_d   = stall_q;
    araddr_d  = araddr_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    awaddr_d  = awaddr_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    wdata_d   = wdata_q;
    wlast_d   = wlast_q;
    done_d    = 1'b0;
    wsum      = '0;

    unique case (state_q)
      StIdle: begin
        if (cmd_rd_start) begin
          state_d   = StAr;
          addr_d    = cmd_addr;
          len_d     = cmd_len;
          beat_d    = '0;
          araddr_d  = cmd_addr;
          arvalid_d = 1'b1;
        end else if (cmd_wr_start) begin
          state_d   = StAw;
          addr_d    = cmd_addr;
          len_d     = cmd_len;
          beat_d    = '0;
          awaddr_d  = cmd_addr;
          awvalid_d = 1'b1;
        end
      end

      StAr: begin
        if (m1_arready) begin
          state_d   = StR;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;  // throttle count 0 is never the stall slot
          stall_d   = '0;
        end
      end

      StR: begin
        if (r_fire) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == len_q) begin
            state_d  = StDone;
            rready_d = 1'b0;
            done_d   = 1'b1;
          end
        end
        // Throttle: count 0..N, rready low while the count sits at N.
        if ((state_d == StR) && (RREADY_STALL != 0)) begin
          stall_d  = (stall_q == RREADY_STALL) ? '0 : stall_q + 32'd1;
          rready_d = (stall_d != RREADY_STALL);
        end
      end

      StAw: begin
        if (m1_awready) begin
          state_d   = StW;
          awvalid_d = 1'b0;
          wvalid_d  = 1'b1;
          wsum      = addr_q;
          wdata_d   = DATA_W'(wsum);
          wlast_d   = (len_q == '0);
        end
      end

      StW: begin
        if (m1_wready) begin
          if (beat_q == len_q) begin
            state_d  = StDone;
            wvalid_d = 1'b0;
            wlast_d  = 1'b0;
            done_d   = 1'b1;
          end else begin
            beat_d  = beat_q + 1'b1;
            wsum    = addr_q + ADDR_W'(beat_d);
            wdata_d = DATA_W'(wsum);
            wlast_d = (beat_d == len_q);
          end
        end
      end

      StDone: state_d = StIdle;

      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      stall_q   <= '0;
      araddr_q  <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awaddr_q  <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      wdata_q   <= '0;
      wlast_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
      stall_q   <= stall_d;
      araddr_q  <= araddr_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      awaddr_q  <= awaddr_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      wdata_q   <= wdata_d;
      wlast_q   <= wlast_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  axi_master_rchk #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W),
    .ERRC_W (ERRC_W)
  ) u_rchk (
    .clk       (clk),
    .rst_n     (rst_n),
    .beat_fire (r_fire),
    .base_addr (addr_q),
    .beat_idx  (beat_q),
    .is_last   (beat_q == len_q),
    .rdata     (m1_rdata),
    .rlast     (m1_rlast),
    .err       (err),
    .err_cnt   (err_cnt)
  );

  assign busy       = busy_q;
  assign done       = done_q;
  assign m1_araddr  = araddr_q;
  assign m1_arvalid = arvalid_q;
  assign m1_rready  = rready_q;
  assign m1_awaddr  = awaddr_q;
  assign m1_awvalid = awvalid_q;
  assign m1_wvalid  = wvalid_q;
  assign m1_wdata   = wdata_q;
  assign m1_wstrb   = WSTRB_ALL;
  assign m1_wlast   = wlast_q;

endmodule
